// File: rtl/coin_pkg.sv
// Shared definitions for the coin dispense sequencer.
// Holds the sequencer state encoding, the denomination indices used
// for servo_open / beam / beam_ack bit positions, the value of each coin
// in cents, and a helper that turns a denomination index into a one-hot
// gate/channel mask.
package coin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    OPEN,
    WAIT_BEAM,
    SETTLE,
    DONE,
    JAM
  } state_t;

  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_5  = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [1:0] COIN_25 = 2'd3;

  localparam logic [7:0] COIN_CENTS [4] = '{8'd1, 8'd5, 8'd10, 8'd25};

  function automatic logic [3:0] coin_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/coin_dispense_sequencer_if.sv
// Bus between the CPU register block / beam-break logic and the sequencer.
//   master : drives start, abort, cnt_1/5/10/25 and beam; observes results
//   slave  : the sequencer; drives servo_open, beam_ack, busy, done, jam,
//            jam_coin and total_cents
interface coin_dispense_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cnt_1;
  logic [CNT_W-1:0] cnt_5;
  logic [CNT_W-1:0] cnt_10;
  logic [CNT_W-1:0] cnt_25;
  logic [3:0]       beam;
  logic [3:0]       servo_open;
  logic [3:0]       beam_ack;
  logic             busy;
  logic             done;
  logic             jam;
  logic [1:0]       jam_coin;
  logic [15:0]      total_cents;

  modport master (
    output start, abort, cnt_1, cnt_5, cnt_10, cnt_25, beam,
    input  servo_open, beam_ack, busy, done, jam, jam_coin, total_cents
  );

  modport slave (
    input  start, abort, cnt_1, cnt_5, cnt_10, cnt_25, beam,
    output servo_open, beam_ack, busy, done, jam, jam_coin, total_cents
  );
endinterface

// File: rtl/coin_dispense_sequencer_timer.sv
// dispense_timer: 32-bit up-counter shared by the hold, beam-timeout and
// settle phases of the sequencer.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : restart counting from zero on the next edge
//   limit        : terminal value (phase length minus one)
//   term         : high while the count equals limit
module dispense_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] limit,
  output logic        term
);

  logic [31:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else                count <= count + 32'd1;
  end

  assign term = (count == limit);

endmodule

// File: rtl/coin_dispense_sequencer.sv
// coin_dispense_sequencer: dispenses a requested mix of 1c/5c/10c/25c coins
// by opening one coin-gate servo at a time and confirming each coin on its
// beam-break channel, with timeout, retry and jam reporting.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : start/abort/cnt_* and beam in; servo_open, beam_ack,
//                  busy, done, jam, jam_coin, total_cents out
// Optional feature: define COIN_TALLY_EN to accumulate total_cents per
// confirmed coin (saturating); otherwise total_cents is constant zero.
module coin_dispense_sequencer
  import coin_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int HOLD_CYCLES    = 9_000_000,
  parameter int TIMEOUT_CYCLES = 30_000_000,
  parameter int SETTLE_CYCLES  = 3_000_000,
  parameter int MAX_RETRY      = 2
) (
  input logic clock,
  input logic reset,
  coin_dispense_sequencer_if.slave bus
);

  state_t           state, state_next;
  logic [CNT_W-1:0] rem [4];
  logic [1:0]       sel, sel_next;
  logic [7:0]       retry;
  logic [3:0]       servo_open_q, beam_ack_q, ack_next, keep_mask;
  logic             jam_q;
  logic [1:0]       jam_coin_q;
  logic             accept, coin_ok, retry_inc, aborting;
  logic [31:0]      timer_limit;
  logic             timer_term;

  dispense_timer u_timer (
    .clock (clock),
    .reset (reset),
    .clear (state_next != state),
    .limit (timer_limit),
    .term  (timer_term)
  );

  // Next-state logic. A beam on the selected channel wins over a timeout
  // landing in the same cycle; abort overrides everything outside IDLE.
  always_comb begin
    state_next  = state;
    sel_next    = sel;
    accept      = 1'b0;
    coin_ok     = 1'b0;
    retry_inc   = 1'b0;
    timer_limit = '0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          accept     = 1'b1;
          state_next = SELECT;
        end
      end
      SELECT: begin
        if      (rem[COIN_25] != '0) begin sel_next = COIN_25; state_next = OPEN; end
        else if (rem[COIN_10] != '0) begin sel_next = COIN_10; state_next = OPEN; end
        else if (rem[COIN_5]  != '0) begin sel_next = COIN_5;  state_next = OPEN; end
        else if (rem[COIN_1]  != '0) begin sel_next = COIN_1;  state_next = OPEN; end
        else                         state_next = DONE;
      end
      OPEN: begin
        timer_limit = 32'(HOLD_CYCLES - 1);
        if (timer_term) state_next = WAIT_BEAM;
      end
      WAIT_BEAM: begin
        timer_limit = 32'(TIMEOUT_CYCLES - 1);
        if (bus.beam[sel] && !beam_ack_q[sel]) begin
          coin_ok    = 1'b1;
          state_next = SETTLE;
        end else if (timer_term) begin
          if (retry < 8'(MAX_RETRY)) begin
            retry_inc  = 1'b1;
            state_next = OPEN;
          end else begin
            state_next = JAM;
          end
        end
      end
      SETTLE: begin
        timer_limit = 32'(SETTLE_CYCLES - 1);
        if (timer_term) state_next = SELECT;
      end
      DONE:    state_next = IDLE;
      JAM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    aborting = (state != IDLE) && bus.abort;
    if (aborting) begin
      state_next = IDLE;
      coin_ok    = 1'b0;
      retry_inc  = 1'b0;
    end
  end

  // The selected channel is left pending while its gate is open or being
  // watched so the coin is counted, not swallowed by the stray-beam ack.
  // Channels whose ack is already out are masked to avoid a second pulse
  // before the beam-break block clears its sticky flag.
  always_comb begin
    keep_mask = '0;
    if (state == OPEN || state == WAIT_BEAM) keep_mask = coin_onehot(sel);
    ack_next = bus.beam & ~beam_ack_q & ~keep_mask;
    if (coin_ok)  ack_next = ack_next | coin_onehot(sel);
    if (aborting) ack_next = 4'hF;
  end

  // State, counts and registered outputs. servo_open is derived from the
  // next state so the gate drive comes straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sel          <= COIN_1;
      retry        <= '0;
      servo_open_q <= '0;
      beam_ack_q   <= '0;
      jam_q        <= 1'b0;
      jam_coin_q   <= COIN_1;
      for (int i = 0; i < 4; i++) rem[i] <= '0;
    end else begin
      state        <= state_next;
      sel          <= sel_next;
      beam_ack_q   <= ack_next;
      servo_open_q <= (state_next == OPEN) ? coin_onehot(sel_next) : 4'h0;
      if (accept) begin
        rem[COIN_1]  <= bus.cnt_1;
        rem[COIN_5]  <= bus.cnt_5;
        rem[COIN_10] <= bus.cnt_10;
        rem[COIN_25] <= bus.cnt_25;
        jam_q        <= 1'b0;
        jam_coin_q   <= COIN_1;
      end
      if (state == SELECT)  retry <= '0;
      else if (retry_inc)   retry <= retry + 8'd1;
      if (coin_ok && rem[sel] != '0) rem[sel] <= rem[sel] - CNT_W'(1);
      if (state_next == JAM) begin
        jam_q      <= 1'b1;
        jam_coin_q <= sel;
      end
    end
  end

`ifdef COIN_TALLY_EN
  logic [15:0] total_q;
  logic [16:0] total_sum;

  always_comb total_sum = {1'b0, total_q} + 17'(COIN_CENTS[sel]);

  // Running tally of confirmed coins, saturating at 16'hFFFF.
  always_ff @(posedge clock) begin
    if (reset)        total_q <= '0;
    else if (accept)  total_q <= '0;
    else if (coin_ok) total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
  end

  assign bus.total_cents = total_q;
`else
  assign bus.total_cents = 16'h0;
`endif

  assign bus.servo_open = servo_open_q;
  assign bus.beam_ack   = beam_ack_q;
  assign bus.busy       = (state == SELECT) || (state == OPEN) ||
                          (state == WAIT_BEAM) || (state == SETTLE);
  assign bus.done       = (state == DONE);
  assign bus.jam        = jam_q;
  assign bus.jam_coin   = jam_coin_q;

endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// Testbench for coin_dispense_sequencer with short phase lengths
// (HOLD=4, TIMEOUT=20, SETTLE=2, MAX_RETRY=2). A small beam-break model
// keeps beam flags sticky until acknowledged; a monitor logs gate openings.
module tb_coin_dispense_sequencer;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;
  localparam int SETTLE  = 2;
  localparam int RETRY   = 2;
`ifdef COIN_TALLY_EN
  localparam int EXP_MIX_TOTAL   = 32;
  localparam int EXP_STRAY_TOTAL = 25;
`else
  localparam int EXP_MIX_TOTAL   = 0;
  localparam int EXP_STRAY_TOTAL = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic [3:0] beam_req;

  int checks = 0;
  int errors = 0;

  coin_dispense_sequencer_if #(.CNT_W(8)) bus ();

  coin_dispense_sequencer #(
    .CNT_W(8), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT),
    .SETTLE_CYCLES(SETTLE), .MAX_RETRY(RETRY)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Beam-break model: flags set on request, held until acknowledged.
  always @(posedge clock) begin
    if (reset) bus.beam <= 4'h0;
    else       bus.beam <= (bus.beam & ~bus.beam_ack) | beam_req;
  end

  function automatic int idx_of(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Monitor of gate activity and done pulses.
  int open_q[$];
  int open_cycles = 0;
  int done_count  = 0;
  int onehot_err  = 0;
  logic [3:0] prev_open = 4'h0;

  always @(negedge clock) begin
    if (bus.servo_open != 4'h0 && bus.servo_open != prev_open) open_q.push_back(idx_of(bus.servo_open));
    if (bus.servo_open != 4'h0) open_cycles++;
    if (bus.done === 1'b1) done_count++;
    if (!$onehot0(bus.servo_open)) onehot_err++;
    prev_open = bus.servo_open;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_monitor();
    open_q.delete();
    open_cycles = 0;
    done_count  = 0;
  endtask

  task automatic set_counts(input int c25, input int c10, input int c5, input int c1);
    bus.cnt_25 = 8'(c25);
    bus.cnt_10 = 8'(c10);
    bus.cnt_5  = 8'(c5);
    bus.cnt_1  = 8'(c1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  function automatic int open_code();
    int c = 0;
    foreach (open_q[i]) c = c * 10 + open_q[i] + 1;
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (bus.servo_open !== 4'h0) begin errors++; $display("[TB] FAIL reset_servo_open got %h want 0", bus.servo_open); end
    checks++;
    if (bus.beam_ack !== 4'h0) begin errors++; $display("[TB] FAIL reset_beam_ack got %h want 0", bus.beam_ack); end
    checks++;
    if ({bus.busy, bus.done, bus.jam, bus.jam_coin} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags got busy=%b done=%b jam=%b jam_coin=%0d want all 0", bus.busy, bus.done, bus.jam, bus.jam_coin);
    end
    checks++;
    if (bus.total_cents !== 16'h0) begin errors++; $display("[TB] FAIL reset_total got %0d want 0", bus.total_cents); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mix();
    logic [3:0] last_open = 4'h0, pend = 4'h0;
    int delay = 0;
    bit seen_done = 0;
    clear_monitor();
    set_counts(1, 0, 1, 2);
    pulse_start();
    for (int i = 0; i < 400 && !seen_done; i++) begin
      tick();
      beam_req = 4'h0;
      if (delay > 0) begin delay--; if (delay == 0) beam_req = pend; end
      if (last_open != 4'h0 && bus.servo_open == 4'h0) begin pend = last_open; delay = 3; end
      last_open = bus.servo_open;
      if (bus.done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mix_busy_at_done got %b want 0", bus.busy); end
      end
    end
    beam_req = 4'h0;
    tick(); tick();
    checks++;
    if (open_code() != 4211) begin errors++; $display("[TB] FAIL mix_servo_order got code %0d want 4211 (25,5,1,1)", open_code()); end
    checks++;
    if (open_cycles != 4 * HOLD) begin errors++; $display("[TB] FAIL mix_open_cycles got %0d want %0d", open_cycles, 4 * HOLD); end
    checks++;
    if (done_count != 1) begin errors++; $display("[TB] FAIL mix_done_count got %0d want 1", done_count); end
    checks++;
    if (bus.total_cents !== 16'(EXP_MIX_TOTAL)) begin errors++; $display("[TB] FAIL mix_total got %0d want %0d", bus.total_cents, EXP_MIX_TOTAL); end
    checks++;
    if (bus.jam !== 1'b0) begin errors++; $display("[TB] FAIL mix_jam got %b want 0", bus.jam); end
  endtask

  task automatic test_jam();
    bit seen_jam = 0;
    clear_monitor();
    set_counts(0, 1, 0, 0);
    pulse_start();
    for (int i = 0; i < 300 && !seen_jam; i++) begin
      tick();
      if (bus.jam === 1'b1) seen_jam = 1;
    end
    checks++;
    if (!seen_jam) begin errors++; $display("[TB] FAIL jam_timeout got jam=%b want 1 within budget", bus.jam); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL jam_busy got %b want 0", bus.busy); end
    checks++;
    if (bus.jam_coin !== 2'd2) begin errors++; $display("[TB] FAIL jam_coin got %0d want 2", bus.jam_coin); end
    checks++;
    if (open_code() != 333) begin errors++; $display("[TB] FAIL jam_opens got code %0d want 333 (three 10c opens)", open_code()); end
    checks++;
    if (open_cycles != 3 * HOLD) begin errors++; $display("[TB] FAIL jam_open_cycles got %0d want %0d", open_cycles, 3 * HOLD); end
    tick(); tick(); tick();
    checks++;
    if (bus.jam !== 1'b1) begin errors++; $display("[TB] FAIL jam_sticky got %b want 1", bus.jam); end
    checks++;
    if (done_count != 0) begin errors++; $display("[TB] FAIL jam_no_done got %0d done pulses want 0", done_count); end
  endtask

  task automatic test_zero();
    clear_monitor();
    set_counts(0, 0, 0, 0);
    pulse_start();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_cycle1 got done=%b busy=%b want done=0 busy=1", bus.done, bus.busy); end
    checks++;
    if (bus.jam !== 1'b0) begin errors++; $display("[TB] FAIL zero_start_clears_jam got %b want 0", bus.jam); end
    tick();
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done_cycle2 got %b want 1", bus.done); end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse_width got %b want 0", bus.done); end
    checks++;
    if (open_q.size() != 0) begin errors++; $display("[TB] FAIL zero_no_open got %0d opens want 0", open_q.size()); end
  endtask

  task automatic test_abort();
    logic [3:0] last_open = 4'h0, pend = 4'h0;
    int delay = 0;
    clear_monitor();
    set_counts(0, 0, 0, 3);
    pulse_start();
    for (int i = 0; i < 100 && open_q.size() < 2; i++) begin
      tick();
      beam_req = 4'h0;
      if (delay > 0) begin delay--; if (delay == 0) beam_req = pend; end
      if (last_open != 4'h0 && bus.servo_open == 4'h0) begin pend = last_open; delay = 3; end
      last_open = bus.servo_open;
    end
    beam_req = 4'h0;
    tick();
    checks++;
    if (bus.servo_open !== 4'b0001) begin errors++; $display("[TB] FAIL abort_pre_open got %h want 1", bus.servo_open); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.servo_open !== 4'h0) begin errors++; $display("[TB] FAIL abort_servo_closed got %h want 0", bus.servo_open); end
    checks++;
    if (bus.beam_ack !== 4'hF) begin errors++; $display("[TB] FAIL abort_ack_all got %h want f", bus.beam_ack); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle got busy=%b want 0", bus.busy); end
    tick();
    checks++;
    if (bus.beam_ack !== 4'h0) begin errors++; $display("[TB] FAIL abort_ack_pulse got %h want 0", bus.beam_ack); end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (done_count != 0 || open_q.size() != 2) begin
      errors++; $display("[TB] FAIL abort_no_resume got done=%0d opens=%0d want 0 and 2", done_count, open_q.size());
    end
  endtask

  task automatic test_stray_and_busy_start();
    logic [3:0] last_open = 4'h0;
    bit closed = 0, seen_done = 0;
    int stray_acks = 0, early_25_acks = 0;
    clear_monitor();
    set_counts(1, 0, 0, 0);
    pulse_start();
    for (int i = 0; i < 30 && !closed; i++) begin
      tick();
      if (last_open == 4'b1000 && bus.servo_open == 4'h0) closed = 1;
      last_open = bus.servo_open;
    end
    set_counts(0, 0, 0, 5);
    beam_req  = 4'b0001;
    bus.start = 1'b1;
    tick();
    beam_req  = 4'h0;
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.beam_ack == 4'b0001) stray_acks++;
      if (bus.beam_ack[3]) early_25_acks++;
    end
    checks++;
    if (stray_acks != 1) begin errors++; $display("[TB] FAIL stray_ack_pulses got %0d want 1", stray_acks); end
    checks++;
    if (early_25_acks != 0 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL stray_not_counted got ack25=%0d busy=%b want 0 and 1", early_25_acks, bus.busy);
    end
    beam_req = 4'b1000;
    tick();
    beam_req = 4'h0;
    for (int i = 0; i < 30 && !seen_done; i++) begin
      tick();
      if (bus.done === 1'b1) seen_done = 1;
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (open_code() != 4) begin errors++; $display("[TB] FAIL busy_start_ignored got code %0d want 4 (single 25c open)", open_code()); end
    checks++;
    if (done_count != 1) begin errors++; $display("[TB] FAIL stray_done_count got %0d want 1", done_count); end
    checks++;
    if (bus.total_cents !== 16'(EXP_STRAY_TOTAL)) begin errors++; $display("[TB] FAIL stray_total got %0d want %0d", bus.total_cents, EXP_STRAY_TOTAL); end
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] last_open = 4'h0;
    bit closed = 0;
    clear_monitor();
    set_counts(0, 0, 1, 0);
    pulse_start();
    for (int i = 0; i < 30 && !closed; i++) begin
      tick();
      if (last_open == 4'b0010 && bus.servo_open == 4'h0) closed = 1;
      last_open = bus.servo_open;
    end
    tick(); tick(); tick();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midwait_busy got %b want 1", bus.busy); end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.servo_open, bus.beam_ack, bus.busy, bus.done, bus.jam, bus.jam_coin} !== 13'b0 || bus.total_cents !== 16'h0) begin
      errors++; $display("[TB] FAIL midwait_reset_outputs got servo=%h ack=%h busy=%b done=%b jam=%b coin=%0d total=%0d want all 0",
                        bus.servo_open, bus.beam_ack, bus.busy, bus.done, bus.jam, bus.jam_coin, bus.total_cents);
    end
    reset = 1'b0;
    open_q.delete();
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (open_q.size() != 0 || bus.busy !== 1'b0 || done_count != 0) begin
      errors++; $display("[TB] FAIL midwait_idle got opens=%0d busy=%b done=%0d want 0", open_q.size(), bus.busy, done_count);
    end
  endtask

  initial begin
    reset     = 1'b1;
    beam_req  = 4'h0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_counts(0, 0, 0, 0);
    $display("[TB] starting coin_dispense_sequencer bench");
    test_reset();
    test_mix();
    test_jam();
    test_zero();
    test_abort();
    test_stray_and_busy_start();
    test_reset_mid_wait();
    checks++;
    if (onehot_err != 0) begin errors++; $display("[TB] FAIL servo_onehot got %0d bad cycles want 0", onehot_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
